// File: rtl/level_sequencer.sv
// Level sequencer for the memory game. It steps through the levels, requests one
// pattern display per attempt, owns the life counter and flags win or game-over.
module level_sequencer #(
  parameter int NUM_LEVELS = 3,
  parameter int MAX_LIFE   = 3,
  parameter bit WRAP_MODE  = 1'b0,
  localparam int LVL_W     = $clog2(NUM_LEVELS),
  localparam int LIFE_W    = $clog2(MAX_LIFE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              ans_valid,
  input  logic              ans_correct,
  output logic              disp,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives,
  output logic              busy,
  output logic              game_won,
  output logic              game_over
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SHOW = 3'd1,
    S_WAIT = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;

  localparam logic [LVL_W-1:0]  LAST_LVL  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0] FULL_LIFE = LIFE_W'(MAX_LIFE);
  localparam logic [LIFE_W-1:0] ONE_LIFE  = LIFE_W'(1);

  state_t             state, state_n;
  logic [LVL_W-1:0]   level_n;
  logic [LIFE_W-1:0]  lives_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      level <= '0;
      lives <= FULL_LIFE;
    end else if (en) begin
      state <= state_n;
      level <= level_n;
      lives <= lives_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    lives_n = lives;
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_n = S_SHOW;
          level_n = '0;
          lives_n = FULL_LIFE;
        end
      end
      S_SHOW: state_n = S_WAIT;
      S_WAIT: begin
        if (ans_valid) begin
          if (ans_correct) begin
            if (level != LAST_LVL) begin
              level_n = level + LVL_W'(1);
              state_n = S_SHOW;
            end else if (WRAP_MODE) begin
              level_n = '0;
              state_n = S_SHOW;
            end else begin
              state_n = S_WIN;
            end
          end else if (lives > ONE_LIFE) begin
            // wrong answer with lives to spare: replay the same level
            lives_n = lives - ONE_LIFE;
            state_n = S_SHOW;
          end else begin
            lives_n = '0;
            state_n = S_LOSE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        level_n = '0;
        lives_n = FULL_LIFE;
      end
    endcase
  end

  // all flags come straight from the state register, no input reaches an output
  assign disp      = (state == S_SHOW);
  assign busy      = (state == S_SHOW) || (state == S_WAIT);
  assign game_won  = (state == S_WIN);
  assign game_over = (state == S_LOSE);

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: a vector table for the main game flow plus
// hand-written sequences for async reset, en hold and wrap mode.
module tb_level_sequencer;

  logic clk = 1'b0;
  logic reset, reset_w;
  logic en, start, ans_valid, ans_correct;

  logic       disp, busy, game_won, game_over;
  logic [1:0] level, lives;
  logic       disp_w, busy_w, won_w, over_w;
  logic [1:0] level_w, lives_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  level_sequencer #(.NUM_LEVELS(3), .MAX_LIFE(3), .WRAP_MODE(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .ans_valid(ans_valid), .ans_correct(ans_correct),
    .disp(disp), .level(level), .lives(lives), .busy(busy),
    .game_won(game_won), .game_over(game_over)
  );

  level_sequencer #(.NUM_LEVELS(3), .MAX_LIFE(3), .WRAP_MODE(1'b1)) dut_w (
    .clk(clk), .reset(reset_w), .en(en), .start(start),
    .ans_valid(ans_valid), .ans_correct(ans_correct),
    .disp(disp_w), .level(level_w), .lives(lives_w), .busy(busy_w),
    .game_won(won_w), .game_over(over_w)
  );

  // packed view: {disp, level[1:0], lives[1:0], busy, won, over}
  typedef struct packed {
    logic       en, start, av, ac;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] pk(input logic d, input logic [1:0] l, input logic [1:0] v,
                                    input logic b, input logic w, input logic o);
    return {d, l, v, b, w, o};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {disp,lvl,lives,busy,won,over}=%b required %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic v, input logic c);
    en = e; start = s; ans_valid = v; ans_correct = c;
  endtask

  // apply current inputs across one posedge, then sample 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  logic [7:0] held;

  initial begin
    drive(0, 0, 0, 0);
    reset = 1'b0;
    reset_w = 1'b0;
    #12;
    chk("reset_state", pk(disp, level, lives, busy, game_won, game_over), pk(0, 0, 3, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    //                 en st av ac    disp lvl lives busy won over
    tbl.push_back('{1, 1, 0, 0, pk(1, 0, 3, 1, 0, 0)}); // start -> SHOW L0
    tbl.push_back('{1, 0, 0, 0, pk(0, 0, 3, 1, 0, 0)}); // -> WAIT
    tbl.push_back('{1, 0, 1, 1, pk(1, 1, 3, 1, 0, 0)}); // correct -> SHOW L1
    tbl.push_back('{1, 0, 0, 0, pk(0, 1, 3, 1, 0, 0)});
    tbl.push_back('{1, 0, 1, 1, pk(1, 2, 3, 1, 0, 0)}); // correct -> SHOW L2
    tbl.push_back('{1, 0, 0, 0, pk(0, 2, 3, 1, 0, 0)});
    tbl.push_back('{1, 0, 1, 1, pk(0, 2, 3, 0, 1, 0)}); // correct at last -> WIN
    tbl.push_back('{1, 1, 0, 0, pk(1, 0, 3, 1, 0, 0)}); // start in WIN -> SHOW L0
    tbl.push_back('{1, 1, 0, 0, pk(0, 0, 3, 1, 0, 0)}); // start in SHOW ignored
    tbl.push_back('{1, 1, 0, 0, pk(0, 0, 3, 1, 0, 0)}); // start in WAIT ignored
    tbl.push_back('{1, 0, 1, 1, pk(1, 1, 3, 1, 0, 0)});
    tbl.push_back('{1, 0, 1, 1, pk(0, 1, 3, 1, 0, 0)}); // answer in SHOW ignored
    tbl.push_back('{1, 0, 1, 0, pk(1, 1, 2, 1, 0, 0)}); // wrong -> replay L1
    tbl.push_back('{1, 0, 0, 0, pk(0, 1, 2, 1, 0, 0)});
    tbl.push_back('{1, 0, 1, 0, pk(1, 1, 1, 1, 0, 0)}); // wrong -> replay L1
    tbl.push_back('{1, 0, 0, 0, pk(0, 1, 1, 1, 0, 0)});
    tbl.push_back('{0, 1, 1, 0, pk(0, 1, 1, 1, 0, 0)}); // en=0 holds
    tbl.push_back('{0, 0, 1, 1, pk(0, 1, 1, 1, 0, 0)});
    tbl.push_back('{1, 0, 1, 0, pk(0, 1, 0, 0, 0, 1)}); // last life -> LOSE
    tbl.push_back('{0, 1, 0, 0, pk(0, 1, 0, 0, 0, 1)}); // en=0 start ignored
    tbl.push_back('{1, 0, 1, 1, pk(0, 1, 0, 0, 0, 1)}); // answer in LOSE ignored
    tbl.push_back('{1, 1, 0, 0, pk(1, 0, 3, 1, 0, 0)}); // start in LOSE -> SHOW
    tbl.push_back('{1, 0, 0, 0, pk(0, 0, 3, 1, 0, 0)});
    tbl.push_back('{1, 1, 1, 1, pk(1, 1, 3, 1, 0, 0)}); // start+answer in WAIT: answer wins

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].start, tbl[i].av, tbl[i].ac);
      step();
      chk($sformatf("vec%0d", i), pk(disp, level, lives, busy, game_won, game_over), tbl[i].exp);
    end

    // now in SHOW L1 lives 3; reach WAIT, then en=0 for 10 cycles with toggling inputs
    drive(1, 0, 0, 0);
    step();
    held = pk(0, 1, 3, 1, 0, 0);
    chk("wait_L1", pk(disp, level, lives, busy, game_won, game_over), held);
    for (int k = 0; k < 10; k++) begin
      drive(0, k[0], ~k[0], k[1]);
      step();
      chk($sformatf("en_hold%0d", k), pk(disp, level, lives, busy, game_won, game_over), held);
    end

    // climb to WAIT at level 2, then async reset mid-cycle
    drive(1, 0, 1, 1);
    step();
    drive(1, 0, 0, 0);
    step();
    chk("wait_L2", pk(disp, level, lives, busy, game_won, game_over), pk(0, 2, 3, 1, 0, 0));
    drive(0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", pk(disp, level, lives, busy, game_won, game_over), pk(0, 0, 3, 0, 0, 0));
    @(negedge clk);

    // wrap-mode instance: one wrong answer, then clear all levels
    reset_w = 1'b1;
    drive(1, 1, 0, 0); step();
    chk("w_start", pk(disp_w, level_w, lives_w, busy_w, won_w, over_w), pk(1, 0, 3, 1, 0, 0));
    drive(1, 0, 0, 0); step();
    drive(1, 0, 1, 0); step();
    chk("w_wrong", pk(disp_w, level_w, lives_w, busy_w, won_w, over_w), pk(1, 0, 2, 1, 0, 0));
    for (int lv = 1; lv <= 2; lv++) begin
      drive(1, 0, 0, 0); step();
      drive(1, 0, 1, 1); step();
      chk($sformatf("w_lvl%0d", lv), pk(disp_w, level_w, lives_w, busy_w, won_w, over_w),
          pk(1, 2'(lv), 2, 1, 0, 0));
    end
    drive(1, 0, 0, 0); step();
    drive(1, 0, 1, 1); step();
    chk("w_wrap", pk(disp_w, level_w, lives_w, busy_w, won_w, over_w), pk(1, 0, 2, 1, 0, 0));
    drive(1, 0, 0, 0); step();
    chk("w_after", pk(disp_w, level_w, lives_w, busy_w, won_w, over_w), pk(0, 0, 2, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
